// File: rtl/mfu_seq_ctrl.sv
// Job sequencer for the combinational mfu: registers operand beats into the mfu and
// accumulates its 64-bit result as 4 unsigned 16-bit lanes. Optional macro: MFU_SEQ_SAT_EN.
module mfu_seq_ctrl #(
  parameter int LEN_W = 8,
  parameter int ACC_W = 24
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cfg_start,
  input  logic [2:0]         cfg_mode,
  input  logic [LEN_W-1:0]   cfg_len,
  output logic               cfg_err,
  output logic               busy,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [7:0]         in_a,
  input  logic [31:0]        in_w,
  output logic [7:0]         mfu_a,
  output logic [31:0]        mfu_w,
  output logic [2:0]         mfu_mode,
  input  logic [63:0]        mfu_o,
  output logic               out_valid,
  input  logic               out_ready,
`ifdef MFU_SEQ_SAT_EN
  output logic [4*ACC_W-1:0] out_acc,
  output logic               out_sat
`else
  output logic [4*ACC_W-1:0] out_acc
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    FLUSH = 2'b10,
    DONE  = 2'b11
  } state_t;

  state_t                      state_r, next_state_s;
  logic [LEN_W-1:0]            cnt_r;
  logic                        stage_v_r;
  logic [3:0][ACC_W-1:0]       acc_r, acc_nxt_s;
  logic [7:0]                  mfu_a_r;
  logic [31:0]                 mfu_w_r;
  logic [2:0]                  mfu_mode_r;
  logic                        cfg_err_r, busy_r, in_ready_r, out_valid_r;
  logic [4*ACC_W-1:0]          out_acc_r;
  logic                        busy_nxt_s, in_ready_nxt_s, out_valid_nxt_s;
  logic                        start_ok_s, start_bad_s, hs_s;
`ifdef MFU_SEQ_SAT_EN
  logic                        sat_r, out_sat_r, sat_hit_s;
`endif

  assign start_ok_s  = (state_r == IDLE) && cfg_start && (cfg_mode <= 3'd4);
  assign start_bad_s = (state_r == IDLE) && cfg_start && (cfg_mode >  3'd4);
  // in_ready_r is high exactly in RUN, so this is the operand handshake
  assign hs_s        = in_valid && in_ready_r;

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // FSM next-state logic
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start_ok_s) begin
          next_state_s = (cfg_len == '0) ? DONE : RUN;
        end else begin
          next_state_s = IDLE;
        end
      end
      RUN: begin
        if (hs_s && (cnt_r == LEN_W'(1))) begin
          next_state_s = FLUSH;
        end else begin
          next_state_s = RUN;
        end
      end
      FLUSH:   next_state_s = DONE;
      DONE: begin
        if (out_ready) begin
          next_state_s = IDLE;
        end else begin
          next_state_s = DONE;
        end
      end
      default: next_state_s = IDLE;
    endcase
  end

  // FSM output decode, taken from the next state so the ports come straight off flops
  always_comb begin
    busy_nxt_s      = 1'b0;
    in_ready_nxt_s  = 1'b0;
    out_valid_nxt_s = 1'b0;
    case (next_state_s)
      IDLE:    busy_nxt_s = 1'b0;
      RUN: begin
        busy_nxt_s     = 1'b1;
        in_ready_nxt_s = 1'b1;
      end
      FLUSH:   busy_nxt_s = 1'b1;
      DONE: begin
        busy_nxt_s      = 1'b1;
        out_valid_nxt_s = 1'b1;
      end
      default: busy_nxt_s = 1'b0;
    endcase
  end

  // Lane accumulation of the staged mfu result; cleared on job start
  always_comb begin : acc_upd
`ifdef MFU_SEQ_SAT_EN
    logic [ACC_W:0] sum;
    sat_hit_s = 1'b0;
`else
    logic [ACC_W-1:0] sum;
`endif
    acc_nxt_s = acc_r;
    sum       = '0;
    for (int i = 0; i < 4; i++) begin
      if (start_ok_s) begin
        acc_nxt_s[i] = '0;
      end else if (stage_v_r) begin
`ifdef MFU_SEQ_SAT_EN
        sum = {1'b0, acc_r[i]} + (ACC_W+1)'(mfu_o[16*i +: 16]);
        if (sum[ACC_W]) begin
          acc_nxt_s[i] = '1;
          sat_hit_s    = 1'b1;
        end else begin
          acc_nxt_s[i] = sum[ACC_W-1:0];
        end
`else
        sum          = acc_r[i] + ACC_W'(mfu_o[16*i +: 16]);
        acc_nxt_s[i] = sum;
`endif
      end else begin
        acc_nxt_s[i] = acc_r[i];
      end
    end
  end

  // Datapath registers: beat capture, counter, stage valid, accumulators
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r      <= '0;
      stage_v_r  <= 1'b0;
      acc_r      <= '0;
      mfu_a_r    <= 8'h00;
      mfu_w_r    <= 32'h0000_0000;
      mfu_mode_r <= 3'b000;
    end else begin
      stage_v_r <= hs_s;
      acc_r     <= acc_nxt_s;
      if (start_ok_s) begin
        cnt_r      <= cfg_len;
        mfu_mode_r <= cfg_mode;
      end else if (hs_s) begin
        cnt_r   <= cnt_r - LEN_W'(1);
        mfu_a_r <= in_a;
        mfu_w_r <= in_w;
      end
    end
  end

  // Registered handshake/status outputs; out_acc only shows the sums while in DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_err_r   <= 1'b0;
      busy_r      <= 1'b0;
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
      out_acc_r   <= '0;
    end else begin
      cfg_err_r   <= start_bad_s;
      busy_r      <= busy_nxt_s;
      in_ready_r  <= in_ready_nxt_s;
      out_valid_r <= out_valid_nxt_s;
      out_acc_r   <= out_valid_nxt_s ? acc_nxt_s : '0;
    end
  end

`ifdef MFU_SEQ_SAT_EN
  // Sticky saturation flag, reported alongside the result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_r     <= 1'b0;
      out_sat_r <= 1'b0;
    end else begin
      if (start_ok_s) begin
        sat_r <= 1'b0;
      end else if (sat_hit_s) begin
        sat_r <= 1'b1;
      end
      out_sat_r <= out_valid_nxt_s && (sat_r || sat_hit_s) && !start_ok_s;
    end
  end

  assign out_sat = out_sat_r;
`endif

  assign cfg_err   = cfg_err_r;
  assign busy      = busy_r;
  assign in_ready  = in_ready_r;
  assign mfu_a     = mfu_a_r;
  assign mfu_w     = mfu_w_r;
  assign mfu_mode  = mfu_mode_r;
  assign out_valid = out_valid_r;
  assign out_acc   = out_acc_r;

endmodule

// File: tb/tb_mfu_seq_ctrl.sv
// Scoreboard bench for mfu_seq_ctrl: expected lane sums are computed per job from the
// issued beats and checked by a monitor when out_valid rises. Honours MFU_SEQ_SAT_EN.
module tb_mfu_seq_ctrl;
  localparam int LEN_W = 8;
  localparam int ACC_W = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              cfg_start = 1'b0;
  logic [2:0]        cfg_mode = 3'b000;
  logic [LEN_W-1:0]  cfg_len = '0;
  logic              cfg_err, busy, in_ready, out_valid;
  logic              in_valid = 1'b0;
  logic [7:0]        in_a = 8'h00;
  logic [31:0]       in_w = 32'h0;
  logic [7:0]        mfu_a;
  logic [31:0]       mfu_w;
  logic [2:0]        mfu_mode;
  logic [63:0]       mfu_o;
  logic              out_ready = 1'b0;
  logic [63:0]       out_acc;
`ifdef MFU_SEQ_SAT_EN
  logic              out_sat;
`endif
  logic              stub_en = 1'b0;
  logic [15:0]       stub_val = 16'h0;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [63:0] acc;
    logic        sat;
  } exp_t;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  mfu_seq_ctrl #(.LEN_W(LEN_W), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start), .cfg_mode(cfg_mode),
    .cfg_len(cfg_len), .cfg_err(cfg_err), .busy(busy), .in_valid(in_valid),
    .in_ready(in_ready), .in_a(in_a), .in_w(in_w), .mfu_a(mfu_a), .mfu_w(mfu_w),
    .mfu_mode(mfu_mode), .mfu_o(mfu_o), .out_valid(out_valid), .out_ready(out_ready),
`ifdef MFU_SEQ_SAT_EN
    .out_acc(out_acc), .out_sat(out_sat)
`else
    .out_acc(out_acc)
`endif
  );

  // Toy mfu: each lane mixes the activation, job mode and one weight byte
  function automatic logic [15:0] mfu_lane(input logic [7:0] a, input logic [31:0] w,
                                           input logic [2:0] m, input int i);
    return {a ^ {5'b00000, m}, w[8*i +: 8]};
  endfunction

  always_comb begin
    mfu_o = 64'h0;
    for (int i = 0; i < 4; i++)
      mfu_o[16*i +: 16] = stub_en ? stub_val : mfu_lane(mfu_a, mfu_w, mfu_mode, i);
  end

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // Monitor: compare each result with the oldest scoreboard entry when out_valid rises
  logic prev_valid = 1'b0;
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst_n) begin
      prev_valid <= 1'b0;
    end else begin
      if (out_valid && !prev_valid) begin
        if (sb_q.size() == 0) begin
          check("sb_unexpected_result", 64'd1, 64'd0);
        end else begin
          e = sb_q.pop_front();
          check("out_acc", out_acc, e.acc);
`ifdef MFU_SEQ_SAT_EN
          check("out_sat", {63'd0, out_sat}, {63'd0, e.sat});
`endif
        end
      end
      prev_valid <= out_valid;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // vmode: 0 = in_valid held 1, 1 = pattern 1,0,0,1,0,1 repeating, 2 = random gaps
  task automatic run_job(input logic [2:0] mode, input int len, input bit use_stub,
                         input logic [15:0] sv, input int vmode, input int hold);
    logic [7:0]  a[$];
    logic [31:0] w[$];
    longint      sum[4];
    exp_t        e;
    int          idx, k;
    bit          v, hs;
    logic [5:0]  pat;
    pat = 6'b101001;
    stub_en  = use_stub;
    stub_val = sv;
    for (int i = 0; i < 4; i++) sum[i] = 0;
    for (int b = 0; b < len; b++) begin
      a.push_back(8'($urandom));
      w.push_back($urandom);
      for (int i = 0; i < 4; i++)
        sum[i] += use_stub ? longint'(sv) : longint'(mfu_lane(a[b], w[b], mode, i));
    end
    e.acc = 64'h0;
    e.sat = 1'b0;
    for (int i = 0; i < 4; i++) begin
`ifdef MFU_SEQ_SAT_EN
      e.acc[16*i +: 16] = (sum[i] > 65535) ? 16'hFFFF : 16'(sum[i]);
`else
      e.acc[16*i +: 16] = 16'(sum[i] % 65536);
`endif
      if (sum[i] > 65535) e.sat = 1'b1;
    end
    sb_q.push_back(e);

    cfg_mode  = mode;
    cfg_len   = LEN_W'(len);
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    if (len > 0) begin
      idx = 0;
      k = 0;
      while (idx < len && k < 4000) begin
        case (vmode)
          0:       v = 1'b1;
          1:       v = pat[k % 6];
          default: v = ($urandom_range(0, 2) != 0);
        endcase
        in_valid = v;
        in_a = a[idx];
        in_w = w[idx];
        @(negedge clk);
        check("in_ready_run", {63'd0, in_ready}, 64'd1);
        check("mfu_mode_run", {61'd0, mfu_mode}, {61'd0, mode});
        hs = in_valid && in_ready;
        tick();
        if (hs) idx++;
        k++;
      end
      if (k >= 4000) check("beat_timeout", 64'(idx), 64'(len));
      if (vmode == 0) check("b2b_cycles", 64'(k), 64'(len));
      in_valid = 1'b0;
      @(negedge clk);
      check("flush_in_ready", {63'd0, in_ready}, 64'd0);
      check("flush_out_valid", {63'd0, out_valid}, 64'd0);
      tick();
    end
    @(negedge clk);
    check("done_out_valid", {63'd0, out_valid}, 64'd1);
    check("done_in_ready", {63'd0, in_ready}, 64'd0);
    check("done_mfu_mode", {61'd0, mfu_mode}, {61'd0, mode});
    for (int h = 0; h < hold; h++) begin
      cfg_start = 1'b1;
      cfg_mode  = (h % 2 == 0) ? 3'b111 : 3'b001;
      tick();
      @(negedge clk);
      check("hold_out_valid", {63'd0, out_valid}, 64'd1);
      check("hold_out_acc", out_acc, e.acc);
      check("hold_cfg_err", {63'd0, cfg_err}, 64'd0);
      check("hold_mfu_mode", {61'd0, mfu_mode}, {61'd0, mode});
    end
    cfg_start = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    @(negedge clk);
    check("idle_busy", {63'd0, busy}, 64'd0);
    check("idle_out_valid", {63'd0, out_valid}, 64'd0);
    check("idle_out_acc", out_acc, 64'd0);
    check("idle_cfg_err", {63'd0, cfg_err}, 64'd0);
    tick();
  endtask

  task automatic bad_start(input logic [2:0] mode);
    cfg_mode  = mode;
    cfg_len   = LEN_W'(5);
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    @(negedge clk);
    check("cfg_err_pulse", {63'd0, cfg_err}, 64'd1);
    check("cfg_err_busy", {63'd0, busy}, 64'd0);
    tick();
    @(negedge clk);
    check("cfg_err_clear", {63'd0, cfg_err}, 64'd0);
    check("cfg_err_idle", {63'd0, busy}, 64'd0);
    tick();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, {63'd0, busy}, 64'd0);
    check({tag, "_in_ready"}, {63'd0, in_ready}, 64'd0);
    check({tag, "_out_valid"}, {63'd0, out_valid}, 64'd0);
    check({tag, "_cfg_err"}, {63'd0, cfg_err}, 64'd0);
    check({tag, "_mfu_a"}, {56'd0, mfu_a}, 64'd0);
    check({tag, "_mfu_w"}, {32'd0, mfu_w}, 64'd0);
    check({tag, "_mfu_mode"}, {61'd0, mfu_mode}, 64'd0);
    check({tag, "_out_acc"}, out_acc, 64'd0);
  endtask

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    #12;
    check_all_zero("reset");
    tick();
    rst_n = 1'b1;
    tick();

    // Lane checks with the constant stub: 3 beats of 4 -> 12 per lane
    run_job(3'b000, 3, 1'b1, 16'h0004, 0, 0);
    run_job(3'b000, 3, 1'b1, 16'h0004, 1, 0);
    // Empty job, then illegal modes
    run_job(3'b000, 0, 1'b0, 16'h0000, 0, 0);
    bad_start(3'b111);
    bad_start(3'b101);
    // Result held while the consumer stalls
    run_job(3'b010, 4, 1'b0, 16'h0000, 0, 5);
    // Long jobs: exact fit and lane wrap/saturation
    run_job(3'b000, 255, 1'b1, 16'h0100, 0, 0);
    run_job(3'b100, 100, 1'b1, 16'h0400, 2, 1);

    // Reset in the middle of a job after 2 of 4 beats
    stub_en   = 1'b0;
    cfg_mode  = 3'b011;
    cfg_len   = LEN_W'(4);
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    in_valid  = 1'b1;
    in_a      = 8'h5A;
    in_w      = 32'hDEAD_BEEF;
    tick();
    tick();
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("midrst");
    tick();
    rst_n = 1'b1;
    tick();
    run_job(3'b000, 1, 1'b1, 16'h0123, 0, 0);

    // Randomized jobs
    for (int j = 0; j < 12; j++) begin
      run_job(3'($urandom_range(0, 4)), ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 24),
              1'b0, 16'h0000, 2, $urandom_range(0, 3));
    end

    repeat (3) tick();
    check("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
